// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring divider, signed/unsigned, one quotient bit per cycle
// Division by zero bypasses ITER but still passes through FIX so both paths share the DONE edge.
module seq_div #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  signed_op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cancel,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_by_zero
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t state, state_n;

   logic [DATA_WIDTH-1:0] a_r, b_r;
   logic                  sop_r;
   logic [DATA_WIDTH-1:0] dvd;
   logic [DATA_WIDTH-1:0] dvs;
   logic [DATA_WIDTH-1:0] prem;
   logic [CW-1:0]         cnt;
   logic                  sign_q, sign_r, dz;
   logic [DATA_WIDTH:0]   trial, diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) state_n = PREP;
         PREP: begin
            if (cancel)         state_n = IDLE;
            else if (b_r == '0) state_n = FIX;
            else                state_n = ITER;
         end
         ITER: begin
            if (cancel)           state_n = IDLE;
            else if (cnt == LAST) state_n = FIX;
         end
         FIX:  state_n = cancel ? IDLE : DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // The stored remainder is always below the divisor, so only the shifted trial needs the extra bit.
   assign trial = {prem, dvd[MSB]};
   assign diff  = trial - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r         <= '0;
         b_r         <= '0;
         sop_r       <= 1'b0;
         dvd         <= '0;
         dvs         <= '0;
         prem        <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dz          <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  sop_r <= signed_op;
               end
            end
            PREP: begin
               dvd    <= (sop_r && a_r[MSB]) ? -a_r : a_r;
               dvs    <= (sop_r && b_r[MSB]) ? -b_r : b_r;
               sign_q <= sop_r && (a_r[MSB] ^ b_r[MSB]);
               sign_r <= sop_r && a_r[MSB];
               dz     <= (b_r == '0);
               prem   <= '0;
               cnt    <= '0;
            end
            ITER: begin
               if (!diff[DATA_WIDTH]) begin
                  prem <= diff[DATA_WIDTH-1:0];
                  dvd  <= {dvd[MSB-1:0], 1'b1};
               end else begin
                  prem <= trial[DATA_WIDTH-1:0];
                  dvd  <= {dvd[MSB-1:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (!cancel) begin
                  if (dz) begin
                     quotient    <= '1;
                     remainder   <= a_r;
                     div_by_zero <= 1'b1;
                  end else begin
                     quotient    <= sign_q ? -dvd : dvd;
                     remainder   <= sign_r ? -prem : prem;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div
module tb_seq_div;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cancel = 1'b0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int n_checks = 0;
   int n_fail   = 0;

   seq_div #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_op   (signed_op),
      .a           (a),
      .b           (b),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // glitch > 0 drives a competing 50/5 start at that many edges into the operation
   task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic sg, input int exp_lat, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz, input int glitch,
                          input logic with_cancel);
      int lat;
      int bc;
      @(negedge clk);
      a = ta; b = tb_v; signed_op = sg; start = 1'b1; cancel = with_cancel;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      lat = 0; bc = 0;
      while (!done && lat < 100) begin
         if (busy) bc++;
         if (glitch > 0 && lat == glitch) begin
            a = 32'd50; b = 32'd5; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, bc, exp_lat);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_div_by_zero"}, div_by_zero, edz);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done, 1'b0);
      check({tag, "_idle_after"}, busy, 1'b0);
   endtask

   initial begin
      int seen;
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", div_by_zero, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      run_div("u100_7",   32'd100,        32'd7,          1'b0, 34, 32'd14,         32'd2,          1'b0, 0, 1'b0);
      run_div("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 34, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0, 1'b0);
      run_div("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 34, 32'hFFFF_FFFD,  32'd1,          1'b0, 0, 1'b0);
      run_div("u5_0",     32'd5,          32'd0,          1'b0, 2,  32'hFFFF_FFFF,  32'd5,          1'b1, 0, 1'b0);
      run_div("u9_3",     32'd9,          32'd3,          1'b0, 34, 32'd3,          32'd0,          1'b0, 0, 1'b0);
      run_div("s5_0",     32'd5,          32'd0,          1'b1, 2,  32'hFFFF_FFFF,  32'd5,          1'b1, 0, 1'b0);
      run_div("s9_3",     32'd9,          32'd3,          1'b1, 34, 32'd3,          32'd0,          1'b0, 0, 1'b0);
      run_div("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 34, 32'h8000_0000,  32'd0,          1'b0, 0, 1'b0);
      run_div("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 34, 32'hFFFF_FFFF,  32'd0,          1'b0, 0, 1'b0);
      run_div("u_ms_by2", 32'hFFFF_FFF9,  32'd2,          1'b0, 34, 32'h7FFF_FFFC,  32'd1,          1'b0, 0, 1'b0);
      run_div("ign_start",32'd100,        32'd7,          1'b0, 34, 32'd14,         32'd2,          1'b0, 5, 1'b0);
      run_div("cxl_start",32'd23,         32'd5,          1'b0, 34, 32'd4,          32'd3,          1'b0, 0, 1'b1);

      // cancel in ITER: outputs keep the 23/5 result, no done pulse follows
      @(negedge clk); a = 32'd200; b = 32'd3; signed_op = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      check("cancel_busy", busy, 1'b0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check("cancel_no_done", seen, 0);
      check("cancel_quotient", quotient, 32'd4);
      check("cancel_remainder", remainder, 32'd3);

      // asynchronous reset mid-cycle during ITER
      @(negedge clk); a = 32'd1000; b = 32'd9; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_quotient", quotient, 32'd0);
      check("arst_remainder", remainder, 32'd0);
      check("arst_dbz", div_by_zero, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_div("post_rst_9_4", 32'd9, 32'd4, 1'b0, 34, 32'd2, 32'd1, 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
